// File: rtl/bounce_game_pkg.sv
// Shared types and constants for the bounce game sequencer.
package bounce_game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } game_st_t;

  localparam int                 SCORE_W   = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;

  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/bounce_game_ctrl_tick_gen.sv
// Loadable down-counter; tick flags terminal count while enabled.
module tick_gen #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == '0);

  // Parks at zero so a counter left enabled never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (en && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RST_VAL;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bounce_game_ctrl.sv
// Game sequencer: paces the bouncing counter, scores key presses, tracks lives.
//   state | meaning
//   IDLE  | waiting for key to start a game
//   RUN   | counter advancing every div clocks, key evaluates position
//   HOLD  | frozen for HOLD_CYC clocks after an evaluation
//   OVER  | no lives left, score shown until key
module bounce_game_ctrl
  import bounce_game_pkg::*;
#(
  parameter int B        = 4,
  parameter int M        = 14,
  parameter int DIV_W    = 24,
  parameter int DIV_INIT = 12_500_000,
  parameter int DIV_STEP = 500_000,
  parameter int DIV_MIN  = 2_000_000,
  parameter int TGT_LO   = 6,
  parameter int TGT_HI   = 8,
  parameter int LIVES    = 3,
  parameter int HOLD_CYC = 25_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key,
  input  logic [B-1:0]       cnt,
  output logic               inc,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               hit,
  output logic               miss,
  output logic               game_over,
  output logic [1:0]         st
);

  if (DIV_MIN < 1 || DIV_MIN > DIV_INIT) begin : g_bad_div
    $error("DIV_MIN must lie in 1..DIV_INIT");
  end
  if (TGT_LO > TGT_HI || TGT_HI > M - 1) begin : g_bad_tgt
    $error("target window must satisfy TGT_LO <= TGT_HI <= M-1");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("HOLD_CYC must be at least 1");
  end
  if (LIVES < 1 || LIVES > 7) begin : g_bad_lives
    $error("LIVES must lie in 1..7");
  end

  localparam int                 HOLD_W     = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYC - 1);
  localparam logic [DIV_W-1:0]   DIV_INIT_V = DIV_W'(DIV_INIT);
  localparam logic [DIV_W-1:0]   DIV_STEP_V = DIV_W'(DIV_STEP);
  localparam logic [DIV_W-1:0]   DIV_MIN_V  = DIV_W'(DIV_MIN);
  localparam logic [DIV_W:0]     DIV_THR    = (DIV_W+1)'(DIV_MIN) + (DIV_W+1)'(DIV_STEP);
  localparam logic [B-1:0]       TGT_LO_V   = B'(TGT_LO);
  localparam logic [B-1:0]       TGT_HI_V   = B'(TGT_HI);
  localparam logic [2:0]         LIVES_V    = 3'(LIVES);

  game_st_t           state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               inc_q, inc_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               game_over_q, game_over_d;

  logic               tick_load, tick_en, tick_tc;
  logic [DIV_W-1:0]   tick_val;
  logic               hold_load, hold_en, hold_tc;
  logic               in_window;

  tick_gen #(.W(DIV_W), .RST_VAL(DIV_W'(DIV_INIT - 1))) u_tick (
    .clk      (clk),
    .rst      (rst),
    .load     (tick_load),
    .load_val (tick_val),
    .en       (tick_en),
    .tick     (tick_tc)
  );

  tick_gen #(.W(HOLD_W), .RST_VAL('0)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .en       (hold_en),
    .tick     (hold_tc)
  );

  assign in_window = (cnt >= TGT_LO_V) && (cnt <= TGT_HI_V);

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    lives_d   = lives_q;
    div_d     = div_q;
    inc_d     = 1'b0;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    tick_load = 1'b0;
    tick_val  = div_q - 1'b1;
    tick_en   = 1'b0;
    hold_load = 1'b0;
    hold_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key) begin
          score_d   = '0;
          lives_d   = LIVES_V;
          div_d     = DIV_INIT_V;
          tick_load = 1'b1;
          tick_val  = DIV_INIT_V - 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        tick_en = 1'b1;
        // A key on the terminal-count cycle suppresses the inc so cnt stays put.
        if (key) begin
          if (in_window) begin
            hit_d   = 1'b1;
            score_d = score_inc(score_q);
            div_d   = ({1'b0, div_q} < DIV_THR) ? DIV_MIN_V : div_q - DIV_STEP_V;
          end else begin
            miss_d  = 1'b1;
            lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
          end
          hold_load = 1'b1;
          state_d   = HOLD;
        end else if (tick_tc) begin
          inc_d     = 1'b1;
          tick_load = 1'b1;
        end
      end
      HOLD: begin
        hold_en = 1'b1;
        if (hold_tc) begin
          if (lives_q == 3'd0) begin
            state_d = OVER;
          end else begin
            state_d   = RUN;
            tick_load = 1'b1;
          end
        end
      end
      OVER: begin
        if (key) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      score_q     <= '0;
      lives_q     <= LIVES_V;
      div_q       <= DIV_INIT_V;
      inc_q       <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      div_q       <= div_d;
      inc_q       <= inc_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      game_over_q <= game_over_d;
    end
  end

  assign inc       = inc_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign game_over = game_over_q;
  assign st        = state_q;

endmodule

// File: tb/tb_bounce_game_ctrl.sv
// Scoreboard bench for bounce_game_ctrl with an attached bouncing counter model.
module tb_bounce_game_ctrl;

  localparam int B        = 4;
  localparam int M        = 14;
  localparam int DIV_INIT = 4;
  localparam int DIV_STEP = 1;
  localparam int DIV_MIN  = 2;
  localparam int LIVES    = 2;
  localparam int HOLD_CYC = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         key;
  logic [B-1:0] cnt;
  logic         inc;
  logic [7:0]   score;
  logic [2:0]   lives;
  logic         hit;
  logic         miss;
  logic         game_over;
  logic [1:0]   st;

  logic         cnt_rst;
  logic         cnt_up;

  typedef struct {
    bit is_hit;
    int score;
    int lives;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int m_score, m_lives, m_div;

  always #5 clk = ~clk;

  bounce_game_ctrl #(
    .B(B), .M(M), .DIV_W(24), .DIV_INIT(DIV_INIT), .DIV_STEP(DIV_STEP),
    .DIV_MIN(DIV_MIN), .TGT_LO(6), .TGT_HI(8), .LIVES(LIVES), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .cnt(cnt), .inc(inc), .score(score),
    .lives(lives), .hit(hit), .miss(miss), .game_over(game_over), .st(st)
  );

  // Bouncing counter: 0 up to M-1, then down to 0, one step per inc.
  always @(posedge clk) begin
    if (cnt_rst) begin
      cnt    <= '0;
      cnt_up <= 1'b1;
    end else if (inc) begin
      if (cnt_up) begin
        if (cnt == B'(M - 1)) begin cnt_up <= 1'b0; cnt <= B'(M - 2); end
        else cnt <= cnt + 1'b1;
      end else begin
        if (cnt == '0) begin cnt_up <= 1'b1; cnt <= 1; end
        else cnt <= cnt - 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (hit || miss) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_pulse", {30'd0, hit, miss}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_hit", hit, e.is_hit);
        chk("sb_miss", miss, !e.is_hit);
        chk("sb_score", score, e.score);
        chk("sb_lives", lives, e.lives);
      end
    end
  end

  task automatic model_reset();
    m_score = 0;
    m_lives = LIVES;
    m_div   = DIV_INIT;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_st"}, st, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_lives"}, lives, LIVES);
    chk({tag, "_inc"}, inc, 0);
    chk({tag, "_hitmiss"}, {hit, miss}, 0);
    chk({tag, "_go"}, game_over, 0);
  endtask

  task automatic start_game();
    key = 1'b1;
    @(negedge clk);
    key = 1'b0;
    model_reset();
    chk("start_st", st, 1);
    chk("start_score", score, 0);
    chk("start_lives", lives, LIVES);
  endtask

  // Called at a negedge while in RUN; leaves the bench at the first HOLD negedge.
  task automatic press_eval(input bit spam);
    int  c;
    bit  is_hit;
    exp_t e;
    c      = int'(cnt);
    key    = 1'b1;
    is_hit = (c >= 6) && (c <= 8);
    if (is_hit) begin
      if (m_score < 255) m_score++;
      m_div = (m_div < DIV_MIN + DIV_STEP) ? DIV_MIN : m_div - DIV_STEP;
    end else if (m_lives > 0) begin
      m_lives--;
    end
    e.is_hit = is_hit;
    e.score  = m_score;
    e.lives  = m_lives;
    sb_q.push_back(e);
    @(negedge clk);
    if (!spam) key = 1'b0;
    chk("eval_st_hold", st, 2);
  endtask

  task automatic hold_check(input string tag);
    int           n;
    bit           inc_seen, cnt_moved;
    logic [B-1:0] c0;
    n = 0; inc_seen = 0; cnt_moved = 0; c0 = cnt;
    while (st == 2'd2 && n < 20) begin
      if (inc) inc_seen = 1;
      if (cnt != c0) cnt_moved = 1;
      n++;
      @(negedge clk);
    end
    key = 1'b0;
    chk({tag, "_len"}, n, HOLD_CYC);
    chk({tag, "_inc"}, inc_seen, 0);
    chk({tag, "_cnt_frozen"}, cnt_moved, 0);
  endtask

  task automatic wait_cnt(input string tag, input int lo, input int hi);
    int n;
    n = 0;
    while (!(st == 2'd1 && int'(cnt) >= lo && int'(cnt) <= hi) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic measure_period(input string tag, input int exp_p);
    int k;
    k = 0;
    while (!inc && k < 100) begin @(negedge clk); k++; end
    if (!inc) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      k = 0;
      do begin @(negedge clk); k++; end while (!inc && k < 100);
      chk(tag, k, exp_p);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  found;
    rst = 1'b1; cnt_rst = 1'b1; key = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0; cnt_rst = 1'b0;
    check_reset("por");

    // Start, first inc latency and steady period.
    @(negedge clk);
    start_game();
    n = 1;
    while (!inc && n < 20) begin @(negedge clk); n++; end
    chk("first_inc_lat", n, 5);
    measure_period("period_init_a", 4);
    measure_period("period_init_b", 4);

    // Three hits: divider 4 -> 3 -> 2 -> 2 (floor); third hit with key spammed in HOLD.
    wait_cnt("hit1_wait", 7, 7);
    press_eval(0);
    hold_check("hold1");
    measure_period("period_div3", 3);
    wait_cnt("hit2_wait", 6, 8);
    press_eval(0);
    hold_check("hold2");
    measure_period("period_div2", 2);
    wait_cnt("hit3_wait", 6, 8);
    press_eval(1);
    hold_check("hold3_spam");
    measure_period("period_floor", 2);

    // Key on the terminal-count cycle with cnt=8: key wins, no inc.
    n = 0; found = 0;
    while (!found && n < 400) begin
      @(negedge clk); n++;
      if (inc) begin
        @(negedge clk); n++;
        if (cnt == 4'd8 && st == 2'd1) found = 1;
      end
    end
    if (!found) chk("kw_find_timeout", 0, 1);
    repeat (m_div - 2) @(negedge clk);
    press_eval(0);
    chk("kw_inc", inc, 0);
    chk("kw_cnt", cnt, 8);
    hold_check("hold_kw");

    // Two misses to game over, then back to IDLE.
    wait_cnt("miss1_wait", 3, 3);
    press_eval(0);
    hold_check("hold_miss1");
    wait_cnt("miss2_wait", 0, 5);
    press_eval(0);
    hold_check("hold_miss2");
    chk("over_st", st, 3);
    chk("over_go", game_over, 1);
    chk("over_score", score, m_score);
    chk("over_lives", lives, 0);
    repeat (2) @(negedge clk);
    chk("over_hold_st", st, 3);
    key = 1'b1;
    @(negedge clk);
    key = 1'b0;
    chk("idle_st", st, 0);
    chk("idle_go", game_over, 0);
    chk("idle_score_kept", score, m_score);

    // Reset during HOLD.
    @(negedge clk);
    start_game();
    wait_cnt("rst_hold_wait", 0, 13);
    press_eval(0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset("rst_hold");

    // Reset during RUN, with key asserted on the same edge.
    start_game();
    repeat (2) @(negedge clk);
    rst = 1'b1; key = 1'b1;
    @(negedge clk);
    rst = 1'b0; key = 1'b0;
    model_reset();
    check_reset("rst_run");
    repeat (10) @(negedge clk);
    chk("rst_run_idle", st, 0);
    chk("sb_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bounce_game_ctrl.md
Name: bounce_game_ctrl

Overview:
Game sequencer for the bouncing position counter (count_circle: up to M-1, then down to 0, advancing on each inc pulse). It paces the counter with a programmable tick and samples the counter position when the player presses the key. It scores hits inside a target window, speeds up play after each hit, and tracks lives until game over. It sits between the debounced key-pulse logic and the counter/display datapath.

Parameters:
B, 4, counter width; must match the counter instance.
M, 14, counter maximum; must match the counter instance. Used only for the elaboration check TGT_HI <= M-1.
DIV_W, 24, width of the tick divider.
DIV_INIT, 12_500_000, clocks per inc at game start; must be >= 1.
DIV_STEP, 500_000, divider decrement applied per hit.
DIV_MIN, 2_000_000, divider floor; must satisfy 1 <= DIV_MIN <= DIV_INIT.
TGT_LO, 6, lowest counter value that scores a hit.
TGT_HI, 8, highest counter value that scores a hit.
LIVES, 3, lives per game; range 1..7.
HOLD_CYC, 25_000_000, freeze length after a key evaluation; must be >= 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
key  in  1  single-cycle pulse, already debounced and edge-detected
cnt  in  B  current value of the counter
inc  out  1  one-cycle advance pulse to the counter
score  out  8  hit count; saturates at 255
lives  out  3  remaining lives
hit  out  1  one-cycle pulse when a key press lands in the window
miss  out  1  one-cycle pulse when a key press lands outside the window
game_over  out  1  high while in the OVER state
st  out  2  state encoding, for display and debug

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, inc=0, hit=0, miss=0, score=0, lives=LIVES, game_over=0, div=DIV_INIT, tick_cnt=DIV_INIT-1, hold_cnt=0.
- Reset asserted mid-game overrides everything on that edge and returns the block to its reset values.
- All outputs are registered. Exception: st is taken directly from the state register.
- FSM states and encodings: IDLE=0, RUN=1, HOLD=2, OVER=3.
- IDLE:
  - inc=0.
  - On key: load score=0, lives=LIVES, div=DIV_INIT, tick_cnt=DIV_INIT-1; go to RUN.
- RUN, pacing:
  - tick_cnt decrements every cycle.
  - When tick_cnt==0: inc=1 on the next cycle and tick_cnt reloads to div-1.
  - Result: inc period is exactly div clocks.
- RUN, key press:
  - cnt is sampled on the same edge that key is seen.
  - If TGT_LO <= cnt <= TGT_HI (unsigned compare):
    - hit=1 on the next cycle.
    - score increments, saturating at 255.
    - div = (div - DIV_STEP < DIV_MIN) ? DIV_MIN : div - DIV_STEP. Compute with no underflow: compare div against DIV_MIN + DIV_STEP.
  - Otherwise: miss=1 on the next cycle and lives decrements.
  - In both cases: go to HOLD with hold_cnt=HOLD_CYC-1.
- Key and tick on the same cycle: the key wins. No inc is issued, so cnt stays frozen at the evaluated value.
- HOLD:
  - inc=0; key is ignored.
  - hold_cnt decrements each cycle. At hold_cnt==0: go to OVER if lives==0, else go to RUN with tick_cnt=div-1.
  - Duration: exactly HOLD_CYC cycles in HOLD.
- OVER:
  - game_over=1, inc=0; score and lives hold their values.
  - On key: go to IDLE. score stays visible until the next game starts.
- lives never decrements below 0. Misses are only possible in RUN, where lives >= 1.
- The controller never drives the counter's reset. The counter keeps its position across games.

Decomposition:
- Package bounce_game_pkg holds:
  - typedef enum logic [1:0] game_st_t {IDLE, RUN, HOLD, OVER}.
  - SCORE_W = 8 and SCORE_MAX = 255.
- Sub-module tick_gen (loadable down-counter):
  - Inputs: clk, rst, load, load_val, en.
  - Output: a tick pulse on terminal count.
  - Used for both tick_cnt and hold_cnt.
- Elaboration checks: DIV_MIN >= 1, DIV_MIN <= DIV_INIT, TGT_LO <= TGT_HI <= M-1, HOLD_CYC >= 1.

Test Plan:
(All scenarios use DIV_INIT=4, DIV_STEP=1, DIV_MIN=2, HOLD_CYC=3, LIVES=2, TGT 6..8, with a count_circle model attached.)
1. rst then key -> st=RUN; inc pulses every 4 clocks; cnt follows 0, 1, ... 13, 12, ...
2. key while cnt=7 -> hit pulse; score=1; exactly 3 cycles in HOLD with no inc; div=3, so the next inc period is 3. A second hit -> div=2. A third hit -> div stays 2.
3. key while cnt=3 -> miss; lives=1. A second miss -> lives=0; after HOLD, st=OVER and game_over=1. Then key -> IDLE.
4. key on the same cycle as tick_cnt==0 with cnt=8 -> hit; no inc issued; cnt stays 8 through HOLD.
5. Assert rst in HOLD and again in RUN -> next edge: IDLE, score=0, lives=2, inc=0; no stray hit or miss pulse.
6. Drive key every cycle during HOLD -> ignored; exactly one hit or miss is counted per evaluation.
